wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone B3 classic slave port among NUM_MASTERS masters (CPU iwb/dwb, DMA wb0m/wb1m).
//  Sits between master ports and one interconnect slave lane, e.g. the shared SRAM.
//  Grant is held for a whole cyc_o cycle, so locked and back-to-back sequences complete atomically.
// PARAMETERS
//  NUM_MASTERS    4    requester count, 2..8
//  WB_ADDR_WIDTH  32   address width
//  WB_DATA_WIDTH  32   data width, multiple of 8
//  TIMEOUT_CYCLES 255  watchdog limit, used only with WB_ARB_TIMEOUT_EN
// PORTS
//  clk       in   1       system clock
//  rst_i     in   1       synchronous reset, active-high
//  m_cyc_i   in   N       per-master cyc
//  m_stb_i   in   N       per-master stb
//  m_we_i    in   N       per-master we
//  m_sel_i   in   N*DW/8  per-master byte selects, master k at [k*DW/8 +: DW/8]
//  m_adr_i   in   N*AW    per-master address, packed the same way
//  m_dat_i   in   N*DW    per-master write data, packed the same way
//  m_dat_o   out  DW      read data, broadcast to all masters (= s_dat_i)
//  m_ack_o   out  N       ack, routed to granted master only
//  m_err_o   out  N       err, routed to granted master only
//  s_cyc_o   out  1       slave cyc
//  s_stb_o   out  1       slave stb
//  s_we_o    out  1       slave we
//  s_sel_o   out  DW/8    slave sel
//  s_adr_o   out  AW      slave adr
//  s_dat_o   out  DW      slave write data
//  s_dat_i   in   DW      slave read data
//  s_ack_i   in   1       slave ack
//  s_err_i   in   1       slave err
//  grant_o   out  N       registered one-hot grant; all-zero when idle
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=0, prio pointer=0, all s_* and m_ack_o/m_err_o=0.
//    Reset mid-transaction drops s_cyc_o on the next edge; no ack is forwarded.
//  - FSM states: IDLE, OWN.
//  - IDLE: when any m_cyc_i is high, register the winner into grant_o and go to OWN (1-cycle arbitration latency).
//    Winner is the first requester at or after the prio pointer, wrapping N-1 -> 0.
//  - OWN: s_* combinationally muxed from the granted master; s_cyc_o = m_cyc_i[g].
//    m_ack_o[g] = s_ack_i & m_cyc_i[g] & m_stb_i[g]; m_err_o follows the same rule.
//    Non-granted masters see ack=err=0.
//  - OWN -> IDLE when m_cyc_i[g] falls. Prio pointer becomes (g+1) mod N.
//    IDLE always lasts at least 1 cycle, so there is no same-cycle regrant.
//  - Simultaneous requests: pointer order decides. Requests arriving during OWN wait.
//  - Ack coincident with cyc drop: ack is still forwarded. A stray s_ack_i in IDLE is ignored.
//  - A requester with cyc high is granted within N*(transaction length + 2) cycles (starvation-free).
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//    8-bit-min counter increments while s_stb_o=1 and s_ack_i|s_err_i=0; it clears on ack, err or IDLE.
//    On reaching TIMEOUT_CYCLES: 1-cycle pulse on m_err_o[g], s_stb_o forced low that cycle, counter clears.
//  WB_ARB_TIMEOUT_EN undefined:
//    No counter. A hung slave holds the grant indefinitely; TIMEOUT_CYCLES is ignored.
// STRUCTURE
//  - Package wb_arb_pkg: enum arb_state_e {ARB_IDLE, ARB_OWN}; function for the packed-slice index.
//  - Sub-module rr_prio_enc:
//    combinational round-robin one-hot select of (req[N], ptr) -> gnt[N].
//    Reusable for the DMA channel arbiter.
// TESTING (N=4, TIMEOUT_CYCLES=8)
//  - Reset with m_cyc_i=4'hF: all outputs 0 while rst_i=1. Release -> grant_o=4'b0001 after 1 cycle.
//  - Persistent m_cyc_i=4'hF, each master running 1-beat cycles:
//    grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
//  - Master2 holds cyc for 3 acked beats while master0 requests:
//    all 3 acks reach m_ack_o[2]; m_ack_o[0]=0; grant switches only after cyc[2] falls.
//  - s_err_i on master1's read: m_err_o=4'b0010 in the same cycle; m_ack_o=0.
//  - rst_i asserted mid-beat with master3 granted: s_cyc_o=0 on the next edge; next winner is master0.
//  - WB_ARB_TIMEOUT_EN, slave never acks:
//    m_err_o[g] pulses exactly 8 cycles after s_stb_o rises.
//    Without the macro: no err; grant is held.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Optional feature macro used by the arbiter: WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Low bit of master idx's lane inside a packed per-master bus of lane width w.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // Wrap an index that may run up to 2n-2 back into 0..n-1.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between NUM_MASTERS Wishbone B3 classic masters, the arbiter,
// and the single shared slave lane.
//
// Handshake: this is classic Wishbone. A master owns a cycle while m_cyc_i is
// high. A beat is offered while m_stb_i is high. The beat completes in the
// cycle where the slave raises ack (or err) while cyc and stb are both high.
// The arbiter adds no buffering. For the granted master, ack/err reach it in
// the same cycle the slave raises them. All other masters see ack=err=0.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS   = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  localparam int N  = NUM_MASTERS;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;

  logic [N-1:0]    m_cyc_i;
  logic [N-1:0]    m_stb_i;
  logic [N-1:0]    m_we_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;

  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [SW-1:0]   s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;

  // The arbiter's view: it receives requests from the masters and drives the slave lane.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  // The surrounding system's view: it models the masters and the slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_prio_enc.sv
// Combinational round-robin one-hot selector.
// The winner is the first requester at or after ptr, wrapping N-1 -> 0.
module rr_prio_enc
  import wb_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic w_found;

  // Scan from the pointer upward; the first request seen wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[wrap_idx(int'(i_ptr) + i, N)]) begin
        o_gnt[wrap_idx(int'(i_ptr) + i, N)] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter that shares one Wishbone B3 classic slave lane among
// NUM_MASTERS masters. A grant is held for a master's whole cyc, so locked and
// back-to-back sequences complete atomically.
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the hung-slave watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int WB_ADDR_WIDTH  = 32,
  parameter  int WB_DATA_WIDTH  = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int N              = NUM_MASTERS,
  localparam int PW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic              clk,
  input  logic              rst_i,
  wb_rr_arbiter_if.slave    bus,
  output logic [N-1:0]      grant_o,
  output arb_state_e        o_dbg_state
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  w_grant_nxt;
  logic [PW-1:0] r_gidx;
  logic [PW-1:0] w_gidx_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_enc_gnt;
  logic [PW-1:0] w_enc_idx;
  logic          w_own;
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          w_stb_raw;
  logic          w_tmo_hit;

  assign w_own     = (r_state == ARB_OWN);
  assign w_own_cyc = bus.m_cyc_i[r_gidx];
  assign w_own_stb = bus.m_stb_i[r_gidx];

  rr_prio_enc #(.N(N)) u_prio_enc (
    .i_req (bus.m_cyc_i),
    .i_ptr (r_ptr),
    .o_gnt (w_enc_gnt)
  );

  // Binary index of the encoder's one-hot winner, used for the data muxes.
  always_comb begin
    w_enc_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_enc_gnt[i]) w_enc_idx = PW'(i);
    end
  end

  // State, grant and priority-pointer registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic. The grant is registered from IDLE and released when the
  // owner drops cyc. IDLE always lasts one full cycle, so there is no
  // same-cycle regrant.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|bus.m_cyc_i) begin
          w_state_nxt = ARB_OWN;
          w_grant_nxt = w_enc_gnt;
          w_gidx_nxt  = w_enc_idx;
        end
      end
      ARB_OWN: begin
        if (!w_own_cyc) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Slave-lane mux and response routing; everything is quiet outside OWN.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    w_stb_raw   = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (w_own) begin
      bus.s_cyc_o = w_own_cyc;
      w_stb_raw   = w_own_stb;
      bus.s_we_o  = bus.m_we_i[r_gidx];
      bus.s_sel_o = bus.m_sel_i[slice_lo(int'(r_gidx), SW) +: SW];
      bus.s_adr_o = bus.m_adr_i[slice_lo(int'(r_gidx), AW) +: AW];
      bus.s_dat_o = bus.m_dat_i[slice_lo(int'(r_gidx), DW) +: DW];
      bus.m_ack_o[r_gidx] = bus.s_ack_i & w_own_cyc & w_own_stb;
      bus.m_err_o[r_gidx] = (bus.s_err_i & w_own_cyc & w_own_stb) | w_tmo_hit;
    end
  end

  // The watchdog cycle takes stb away from the slave while the error is reported.
  assign bus.s_stb_o = w_stb_raw & ~w_tmo_hit;
  assign bus.m_dat_o = bus.s_dat_i;
  assign grant_o     = r_grant;
  assign o_dbg_state = r_state;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] r_tmo;

  assign w_tmo_hit = w_own && (r_tmo == TW'(TIMEOUT_CYCLES));

  // Count stalled strobe cycles. Clear on any response, on expiry, or when not owning.
  always_ff @(posedge clk) begin
    if (rst_i || !w_own || w_tmo_hit || bus.s_ack_i || bus.s_err_i) begin
      r_tmo <= '0;
    end else if (w_stb_raw) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  // No watchdog: a hung slave keeps the grant. TIMEOUT_CYCLES is never negative,
  // so this compare is constant false.
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule
